// File: rtl/mem_access_unit.sv
// MEM stage of the rv32i pipeline: req/ack data-memory port with byte lanes, load alignment, registered MEM/WB.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic [2:0]            ex_funct3,
    input  logic [DATA_WIDTH-1:0] ex_alu_result,
    input  logic [DATA_WIDTH-1:0] ex_mem_wdata,
    input  logic                  ex_reg_write,
    input  logic [4:0]            ex_rd,
    output logic                  stall,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic [4:0]            wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  misalign_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic        mem_op;
    logic        misalign;
    logic        issue;
    logic [2:0]  funct3_p1;
    logic [1:0]  lane_p1;
    logic [4:0]  rd_p1;
    logic        reg_write_p1;

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000:  store_be = 4'b0001 << a;
            3'b001:  store_be = a[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  store_data = {4{d[7:0]}};
            3'b001:  store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = a[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b100:  load_extend = {24'd0, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b101:  load_extend = {16'd0, h};
            default: load_extend = d;
        endcase
    endfunction

`ifdef MEM_MISALIGN_CHECK_EN
    // Byte accesses never misalign; store funct3 100/101 fall back to word size.
    function automatic logic misaligned(input logic [2:0] f3, input logic is_store,
                                        input logic [1:0] a);
        logic is_byte, is_half;
        is_byte = is_store ? (f3 == 3'b000) : (f3[1:0] == 2'b00);
        is_half = is_store ? (f3 == 3'b001) : (f3[1:0] == 2'b01);
        if (is_byte)      misaligned = 1'b0;
        else if (is_half) misaligned = a[0];
        else              misaligned = (a != 2'b00);
    endfunction

    assign misalign = mem_op & misaligned(ex_funct3, ex_mem_write, ex_alu_result[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign mem_op = ex_valid & (ex_mem_read | ex_mem_write);
    assign issue  = (state_q == IDLE) & mem_op & ~misalign;

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    stall   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall = ~dmem_ack;
                if (dmem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Accept (IDLE) -> transfer (BUSY) -> MEM/WB register
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= 4'b0000;
            dmem_wdata   <= '0;
            funct3_p1    <= 3'b000;
            lane_p1      <= 2'b00;
            rd_p1        <= 5'd0;
            reg_write_p1 <= 1'b0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            if (state_q == IDLE) begin
                if (issue) begin
                    dmem_req     <= 1'b1;
                    dmem_we      <= ex_mem_write;
                    dmem_addr    <= {ex_alu_result[ADDR_WIDTH-1:2], 2'b00};
                    dmem_be      <= ex_mem_write ? store_be(ex_funct3, ex_alu_result[1:0]) : 4'b1111;
                    dmem_wdata   <= store_data(ex_funct3, ex_mem_wdata);
                    funct3_p1    <= ex_funct3;
                    lane_p1      <= ex_alu_result[1:0];
                    rd_p1        <= ex_rd;
                    reg_write_p1 <= ex_reg_write & ~ex_mem_write;
                    wb_valid     <= 1'b0;
                    wb_reg_write <= 1'b0;
                end else if (misalign) begin
                    wb_valid     <= 1'b1;
                    wb_reg_write <= 1'b0;
                    wb_rd        <= ex_rd;
                    wb_data      <= ex_alu_result;
                    misalign_err <= 1'b1;
                end else begin
                    wb_valid     <= ex_valid;
                    wb_reg_write <= ex_reg_write & ex_valid;
                    wb_rd        <= ex_rd;
                    wb_data      <= ex_alu_result;
                end
            end else if (dmem_ack) begin
                dmem_req     <= 1'b0;
                wb_valid     <= 1'b1;
                wb_reg_write <= reg_write_p1 & ~dmem_we;
                wb_rd        <= rd_p1;
                wb_data      <= dmem_we ? '0 : load_extend(funct3_p1, lane_p1, dmem_rdata);
            end else begin
                wb_valid     <= 1'b0;
                wb_reg_write <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit plus hand sequences for reset and idle corner cases.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_result, ex_mem_wdata;
    logic [4:0]  ex_rd;
    logic        stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_reg_write, misalign_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result), .ex_mem_wdata(ex_mem_wdata),
        .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign_err(misalign_err)
    );

    typedef struct {
        logic        rd_en;
        logic        wr_en;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_data;
        logic        e_rw;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        ex_valid      = 1'b1;
        ex_mem_read   = v.rd_en;
        ex_mem_write  = v.wr_en;
        ex_funct3     = v.f3;
        ex_alu_result = v.addr;
        ex_mem_wdata  = v.wdata;
        ex_reg_write  = v.rw;
        ex_rd         = v.rd;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        drive(v);
        #1;
        if (!(v.rd_en || v.wr_en)) begin
            chk($sformatf("v%0d_stall", idx), {31'd0, stall}, 32'd0);
            tick();
            ex_valid = 1'b0;
            chk($sformatf("v%0d_wb_valid", idx), {31'd0, wb_valid}, 32'd1);
            chk($sformatf("v%0d_wb_data", idx), wb_data, v.e_data);
            chk($sformatf("v%0d_wb_rd", idx), {27'd0, wb_rd}, {27'd0, v.rd});
            chk($sformatf("v%0d_wb_rw", idx), {31'd0, wb_reg_write}, {31'd0, v.e_rw});
            chk($sformatf("v%0d_req", idx), {31'd0, dmem_req}, 32'd0);
        end else begin
            n = stall ? 1 : 0;
            tick();
            chk($sformatf("v%0d_req", idx), {31'd0, dmem_req}, 32'd1);
            chk($sformatf("v%0d_addr", idx), dmem_addr, v.e_addr);
            chk($sformatf("v%0d_be", idx), {28'd0, dmem_be}, {28'd0, v.e_be});
            chk($sformatf("v%0d_wdata", idx), dmem_wdata, v.e_wdata);
            chk($sformatf("v%0d_we", idx), {31'd0, dmem_we}, {31'd0, v.wr_en});
            chk($sformatf("v%0d_wb_valid_busy", idx), {31'd0, wb_valid}, 32'd0);
            for (int k = 0; k <= v.delay; k++) begin
                if (k == v.delay) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = v.rdata;
                end else begin
                    dmem_rdata = 32'h5A5A_5A5A;
                end
                #1;
                if (stall) n++;
                tick();
            end
            dmem_ack = 1'b0;
            ex_valid = 1'b0;
            #1;
            chk($sformatf("v%0d_stall_cycles", idx), n, v.delay + 1);
            chk($sformatf("v%0d_wb_valid", idx), {31'd0, wb_valid}, 32'd1);
            chk($sformatf("v%0d_wb_data", idx), wb_data, v.e_data);
            chk($sformatf("v%0d_wb_rw", idx), {31'd0, wb_reg_write}, {31'd0, v.e_rw});
            chk($sformatf("v%0d_wb_rd", idx), {27'd0, wb_rd}, {27'd0, v.rd});
            chk($sformatf("v%0d_req_drop", idx), {31'd0, dmem_req}, 32'd0);
        end
    endtask

    initial begin
        // rd_en wr_en f3 addr wdata rw rd rdata delay | e_addr e_be e_wdata e_data e_rw
        vecs.push_back('{1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 1'b1, 5'd5, 32'h0, 0,
                         32'h0, 4'h0, 32'h0, 32'h0000_1234, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 1'b0, 5'd0, 32'h0, 3,
                         32'h0000_1000, 4'b1000, 32'hDDDD_DDDD, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h0000_2002, 32'h0, 1'b1, 5'd7, 32'h1280_FF34, 0,
                         32'h0000_2000, 4'b1111, 32'h0, 32'hFFFF_FF80, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 3'b100, 32'h0000_2002, 32'h0, 1'b1, 5'd7, 32'h1280_FF34, 0,
                         32'h0000_2000, 4'b1111, 32'h0, 32'h0000_0080, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 1'b1, 5'd8, 32'h8001_0000, 1,
                         32'h0000_2000, 4'b1111, 32'h0, 32'hFFFF_8001, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 1'b1, 5'd8, 32'h8001_0000, 0,
                         32'h0000_2000, 4'b1111, 32'h0, 32'h0000_8001, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 1'b0, 5'd0, 32'h0, 0,
                         32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h0000_1001, 32'h1122_3344, 1'b0, 5'd0, 32'h0, 1,
                         32'h0000_1000, 4'b0010, 32'h4444_4444, 32'h0, 1'b0});
        // read and write both set: treated as store, no register write
        vecs.push_back('{1'b1, 1'b1, 3'b010, 32'h0000_1008, 32'h1234_5678, 1'b1, 5'd4, 32'h0, 0,
                         32'h0000_1008, 4'b1111, 32'h1234_5678, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 3'b000, 32'hDEAD_BEEF, 32'h0, 1'b0, 5'd3, 32'h0, 0,
                         32'h0, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h0000_2000, 32'h0, 1'b1, 5'd9, 32'h0000_007F, 2,
                         32'h0000_2000, 4'b1111, 32'h0, 32'h0000_007F, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h0000_2000, 32'h0, 1'b1, 5'd10, 32'h1234_F00F, 0,
                         32'h0000_2000, 4'b1111, 32'h0, 32'hFFFF_F00F, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h0000_2000, 32'h0000_BEEF, 1'b0, 5'd0, 32'h0, 0,
                         32'h0000_2000, 4'b0011, 32'hBEEF_BEEF, 32'h0, 1'b0});
`ifndef MEM_MISALIGN_CHECK_EN
        // misaligned word silently aligned down
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 1'b1, 5'd11, 32'hCAFE_F00D, 0,
                         32'h0000_3000, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b1});
`endif

        rst = 1'b1;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0;
        ex_funct3 = 3'b000; ex_alu_result = 32'h0; ex_mem_wdata = 32'h0; ex_rd = 5'd0;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        tick();
        tick();
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Memory op without ex_valid is not issued
        ex_mem_read = 1'b1; ex_funct3 = 3'b010; ex_alu_result = 32'h0000_5000;
        #1;
        chk("novalid_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("novalid_req", {31'd0, dmem_req}, 32'd0);
        chk("novalid_wb_valid", {31'd0, wb_valid}, 32'd0);

        // Ack while idle is ignored
        ex_mem_read = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'h7777_7777;
        tick();
        dmem_ack = 1'b0;
        chk("idle_ack_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("idle_ack_req", {31'd0, dmem_req}, 32'd0);

        // Reset mid-transfer, ack afterwards is ignored
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = 3'b010;
        ex_alu_result = 32'h0000_4000; ex_reg_write = 1'b1; ex_rd = 5'd9;
        tick();
        chk("midrst_req_busy", {31'd0, dmem_req}, 32'd1);
        chk("midrst_stall_busy", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        ex_valid = 1'b0;
        tick();
        chk("midrst_req", {31'd0, dmem_req}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
        rst = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
        #1;
        chk("midrst_ack_stall", {31'd0, stall}, 32'd0);
        tick();
        dmem_ack = 1'b0;
        chk("midrst_ack_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("midrst_ack_req", {31'd0, dmem_req}, 32'd0);

`ifdef MEM_MISALIGN_CHECK_EN
        // Misaligned word: no transfer, single-cycle error writeback
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_funct3 = 3'b010;
        ex_alu_result = 32'h0000_3001; ex_reg_write = 1'b1; ex_rd = 5'd11;
        #1;
        chk("mis_stall", {31'd0, stall}, 32'd0);
        tick();
        ex_valid = 1'b0;
        chk("mis_req", {31'd0, dmem_req}, 32'd0);
        chk("mis_err", {31'd0, misalign_err}, 32'd1);
        chk("mis_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("mis_wb_rw", {31'd0, wb_reg_write}, 32'd0);
        tick();
        chk("mis_err_clear", {31'd0, misalign_err}, 32'd0);
`else
        chk("misalign_tied", {31'd0, misalign_err}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM stage of the rv32i pipeline, downstream of execution.
- Consumes the EX/MEM values: ALU result as the memory address or pass-through data, and the forwarded rs2 as store data.
- Drives a req/ack data-memory port with byte lanes. Aligns and extends load data, stalls upstream while a transfer is outstanding, and presents registered MEM/WB outputs.

Parameters:
- ADDR_WIDTH, 32, data-memory byte address width
- DATA_WIDTH, 32, data width (fixed at 32; byte-lane logic assumes 4 lanes)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_funct3  in  3  access size/sign (RISC-V load/store funct3)
- ex_alu_result  in  DATA_WIDTH  address for loads/stores; writeback data otherwise
- ex_mem_wdata  in  DATA_WIDTH  store data, unshifted
- ex_reg_write  in  1  instruction writes rd
- ex_rd  in  5  destination register
- stall  out  1  freeze PC/IF/ID/EX registers
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_WIDTH  word-aligned address, [1:0] = 0
- dmem_be  out  4  byte enables
- dmem_wdata  out  DATA_WIDTH  lane-replicated store data
- dmem_ack  in  1  transfer complete; read data valid this cycle
- dmem_rdata  in  DATA_WIDTH  read word
- wb_valid  out  1  MEM/WB valid
- wb_reg_write  out  1  MEM/WB register write enable
- wb_rd  out  5  MEM/WB destination
- wb_data  out  DATA_WIDTH  load result or pass-through ALU result
- misalign_err  out  1  misaligned access flag; tied 0 unless the feature is enabled

Behaviour:
- FSM states are IDLE and BUSY. Reset: state IDLE, all outputs 0.
- **Memory op:** ex_valid & (ex_mem_read | ex_mem_write).
- **Store priority:** if both read and write are set, the access is a store and wb_reg_write is 0.
- **IDLE with a non-memory op:**
  - wb_valid <= ex_valid, wb_data <= ex_alu_result, wb_rd/wb_reg_write registered (reg_write gated by ex_valid).
  - 1-cycle latency; stall = 0.
- **IDLE with a memory op:**
  - stall = 1 combinationally.
  - Register dmem_addr = {addr[31:2], 2'b00}, dmem_we, dmem_be, dmem_wdata, funct3, addr[1:0], rd and reg_write.
  - dmem_req <= 1, state <= BUSY, wb_valid <= 0.
- **BUSY:**
  - dmem_req held 1 and all dmem_* outputs stable until ack.
  - stall = ~dmem_ack.
  - On ack: dmem_req <= 0, state <= IDLE, wb_valid <= 1, wb_data <= load result (stores: 0, wb_reg_write 0).
  - Upstream advances on the ack cycle; a new op can be accepted the next cycle.
- **Minimum latency:** accept cycle plus ack on the first BUSY cycle gives wb_valid 2 cycles after EX presentation.
- **Store lanes:**
  - SB (000): be = 1 << addr[1:0], wdata = {4{byte}}.
  - SH (001): be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{half}}.
  - SW (010): be = 4'b1111.
  - Any other funct3: word access.
- **Loads:** dmem_be = 4'b1111. Lane is selected by the registered addr[1:0].
  - LB (000): sign-extended byte.
  - LBU (100): zero-extended byte.
  - LH (001): sign-extended half (addr[1]).
  - LHU (101): zero-extended half.
  - LW (010) and others: full word.
- **Ignored acks:** dmem_ack in IDLE is ignored, and so is any ack arriving after reset.
- **Reset mid-transfer:** returns to IDLE, drops dmem_req and stall the next cycle, and produces no writeback.
- Upstream must hold ex_* stable while stall = 1.

Optional Feature:
- **Macro:** MEM_MISALIGN_CHECK_EN.
- **Enabled:**
  - A halfword access with addr[0] = 1, or a word access with addr[1:0] != 0, is not issued.
  - No stall; 1-cycle pass-through.
  - wb_valid = 1, wb_reg_write = 0, misalign_err = 1 for that cycle.
- **Disabled:**
  - misalign_err tied 0.
  - Low address bits below the access size are silently ignored: halfword uses addr[1], word ignores [1:0].

Test Plan:
- Non-memory op: addr/ALU 0x0000_1234, rd = 5, reg_write = 1 -> next cycle wb_valid = 1, wb_data = 0x0000_1234, wb_rd = 5; stall never 1.
- SB to 0x1003, data 0xAABBCCDD, ack after 3 BUSY cycles -> dmem_addr 0x1000, be 4'b1000, wdata 0xDDDDDDDD, stall high 4 cycles, wb_reg_write 0.
- LB from 0x2002, rdata 0x1280_FF34, ack on first BUSY cycle -> wb_data 0xFFFF_FF80. The same access as LBU gives 0x0000_0080. wb_valid 2 cycles after issue.
- LH at 0x2002, rdata 0x8001_0000 -> 0xFFFF_8001. LHU gives 0x0000_8001. SH at 0x2002, data 0x0000_BEEF -> be 4'b1100, wdata 0xBEEF_BEEF.
- Reset asserted while BUSY, then ack arrives -> dmem_req and stall 0 after the reset edge, no wb_valid, ack ignored.
- MEM_MISALIGN_CHECK_EN: LW at 0x3001 -> no dmem_req, misalign_err = 1, wb_valid = 1, wb_reg_write = 0. Without the macro: dmem_addr 0x3000, normal load.
